ext_bus_sequencer: RTL and testbench

Parametrised external-memory bus sequencer for the CPU core. It generalises the core's pin-level address/data multiplexing into a handshaked transaction engine. One request is accepted on a valid/ready interface. The block time-multiplexes the ADDR_W-bit address and DATA_W-bit data over PIN_W-wide pad groups, honours external wait states, and returns read data or a write acknowledge with error status on a response strobe.

---
 rtl/ext_bus_sequencer_if.sv | 36 +++
 rtl/ext_bus_sequencer.sv | 162 ++++++++++++++++
 tb/tb_ext_bus_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_sequencer_if.sv
// Request/response handshake and multiplexed pad bus of the external-memory sequencer.
// The sequencer connects through the slave modport; the requester/pad side uses master.
interface ext_bus_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int PIN_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [PIN_W-1:0]  addr_pins;
    logic              ale;
    logic              rw_pin;
    logic [PIN_W-1:0]  data_out;
    logic [PIN_W-1:0]  data_oe;
    logic [PIN_W-1:0]  data_in;
    logic              ext_ready;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, data_in, ext_ready,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, addr_pins, ale, rw_pin,
               data_out, data_oe, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, data_in, ext_ready,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, addr_pins, ale, rw_pin,
               data_out, data_oe, busy
    );
endinterface

// File: rtl/ext_bus_sequencer.sv
// External-memory bus sequencer: one handshaked request is time-multiplexed over the pads
// as address beats then data beats (with wait states and timeout), ending in a response strobe.
module ext_bus_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int PIN_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    ext_bus_sequencer_if.slave bus
);
    localparam int A_BEATS   = ADDR_W / PIN_W;
    localparam int D_BEATS   = DATA_W / PIN_W;
    localparam int MAX_BEATS = (A_BEATS > D_BEATS) ? A_BEATS : D_BEATS;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BEAT_W-1:0] A_LAST    = BEAT_W'(A_BEATS - 1);
    localparam logic [BEAT_W-1:0] D_LAST    = BEAT_W'(D_BEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t            r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [WAIT_W-1:0] r_wait;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_we;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [PIN_W-1:0]  r_addr_pins;
    logic              r_ale;
    logic              r_rw_pin;
    logic [PIN_W-1:0]  r_data_out;
    logic [PIN_W-1:0]  r_data_oe;
    logic              r_busy;

    logic [DATA_W-1:0] w_rdata_next;
    logic              w_timeout;

    // Address and write data are shift registers: the top slice is always the next beat.
    assign w_rdata_next = (r_rdata << PIN_W) | DATA_W'(bus.data_in);
    assign w_timeout    = (TIMEOUT != 0) && (r_wait == WAIT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_wait      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_we        <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr_pins <= '0;
            r_ale       <= 1'b0;
            r_rw_pin    <= 1'b1;
            r_data_out  <= '0;
            r_data_oe   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_state     <= S_ADDR;
                        r_beat      <= '0;
                        r_we        <= bus.req_we;
                        r_addr      <= bus.req_addr << PIN_W;
                        r_wdata     <= bus.req_wdata;
                        r_rdata     <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ale       <= 1'b1;
                        r_rw_pin    <= ~bus.req_we;
                        r_addr_pins <= bus.req_addr[ADDR_W-1 -: PIN_W];
                    end
                end
                S_ADDR: begin
                    if (r_beat == A_LAST) begin
                        r_state     <= S_DATA;
                        r_beat      <= '0;
                        r_wait      <= '0;
                        r_addr_pins <= '0;
                        r_ale       <= 1'b0;
                        if (r_we) begin
                            r_data_out <= r_wdata[DATA_W-1 -: PIN_W];
                            r_data_oe  <= '1;
                            r_wdata    <= r_wdata << PIN_W;
                        end
                    end else begin
                        r_beat      <= r_beat + BEAT_W'(1);
                        r_addr_pins <= r_addr[ADDR_W-1 -: PIN_W];
                        r_addr      <= r_addr << PIN_W;
                    end
                end
                S_DATA: begin
                    if (bus.ext_ready) begin
                        r_wait <= '0;
                        if (!r_we) begin
                            r_rdata <= w_rdata_next;
                        end
                        if (r_beat == D_LAST) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= r_we ? '0 : w_rdata_next;
                            r_data_out  <= '0;
                            r_data_oe   <= '0;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                            if (r_we) begin
                                r_data_out <= r_wdata[DATA_W-1 -: PIN_W];
                                r_wdata    <= r_wdata << PIN_W;
                            end
                        end
                    end else if (w_timeout) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_data_out  <= '0;
                        r_data_oe   <= '0;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_beat      <= '0;
                    r_wait      <= '0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_rw_pin    <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.addr_pins = r_addr_pins;
    assign bus.ale       = r_ale;
    assign bus.rw_pin    = r_rw_pin;
    assign bus.data_out  = r_data_out;
    assign bus.data_oe   = r_data_oe;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Bench for ext_bus_sequencer: two geometries (16/8 and 24/16 bits), a per-cycle timeline
// model built from transaction descriptions, plus literal checks of latencies and data.
module tb_ext_bus_sequencer;
    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic        req_ready;
        logic        rsp_valid;
        logic        rsp_err;
        logic [15:0] rsp_rdata;
        logic [7:0]  addr_pins;
        logic        ale;
        logic        rw_pin;
        logic [7:0]  data_out;
        logic [7:0]  data_oe;
        logic        busy;
    } outv_t;

    typedef struct packed {
        logic        req_valid;
        logic        req_we;
        logic [23:0] req_addr;
        logic [15:0] req_wdata;
        logic [7:0]  data_in;
        logic        ext_ready;
    } inv_t;

    typedef struct packed {
        inv_t  in;
        outv_t exp;
    } cyc_t;

    logic  clk = 1'b0;
    logic  rst0_n;
    logic  rst1_n;
    int    checks = 0;
    int    errors = 0;
    int    cycleCnt = 0;
    int    expSel = 0;
    bit    expOn = 0;
    outv_t expCur;
    string curLabel = "idle";
    cyc_t  plan[$];
    int    rspAtQ[$];
    int    rspDataQ[$];
    int    rspErrQ[$];
    int    aleQ[$];
    int    acceptQ[$];
    int    oeCnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    ext_bus_sequencer_if #(.ADDR_W(16), .DATA_W(8),  .PIN_W(8)) bus0 ();
    ext_bus_sequencer_if #(.ADDR_W(24), .DATA_W(16), .PIN_W(8)) bus1 ();

    ext_bus_sequencer #(.ADDR_W(16), .DATA_W(8), .PIN_W(8), .TIMEOUT(TIMEOUT)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst0_n), .bus(bus0.slave)
    );
    ext_bus_sequencer #(.ADDR_W(24), .DATA_W(16), .PIN_W(8), .TIMEOUT(TIMEOUT)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst1_n), .bus(bus1.slave)
    );

    function automatic outv_t idleOut();
        outv_t o;
        o = '0;
        o.req_ready = 1'b1;
        o.rw_pin    = 1'b1;
        return o;
    endfunction

    function automatic inv_t junkIn();
        inv_t v;
        v.req_valid = 1'($urandom);
        v.req_we    = 1'($urandom);
        v.req_addr  = 24'($urandom);
        v.req_wdata = 16'($urandom);
        v.data_in   = 8'($urandom);
        v.ext_ready = 1'($urandom);
        return v;
    endfunction

    function automatic outv_t sampleOut(input int sel);
        outv_t o;
        if (sel == 0) begin
            o.req_ready = bus0.req_ready;  o.rsp_valid = bus0.rsp_valid;
            o.rsp_err   = bus0.rsp_err;    o.rsp_rdata = {8'h00, bus0.rsp_rdata};
            o.addr_pins = bus0.addr_pins;  o.ale       = bus0.ale;
            o.rw_pin    = bus0.rw_pin;     o.data_out  = bus0.data_out;
            o.data_oe   = bus0.data_oe;    o.busy      = bus0.busy;
        end else begin
            o.req_ready = bus1.req_ready;  o.rsp_valid = bus1.rsp_valid;
            o.rsp_err   = bus1.rsp_err;    o.rsp_rdata = bus1.rsp_rdata;
            o.addr_pins = bus1.addr_pins;  o.ale       = bus1.ale;
            o.rw_pin    = bus1.rw_pin;     o.data_out  = bus1.data_out;
            o.data_oe   = bus1.data_oe;    o.busy      = bus1.busy;
        end
        return o;
    endfunction

    task automatic driveIn(input int sel, input inv_t v);
        if (sel == 0) begin
            bus0.req_valid = v.req_valid;       bus0.req_we    = v.req_we;
            bus0.req_addr  = v.req_addr[15:0];  bus0.req_wdata = v.req_wdata[7:0];
            bus0.data_in   = v.data_in;         bus0.ext_ready = v.ext_ready;
        end else begin
            bus1.req_valid = v.req_valid;       bus1.req_we    = v.req_we;
            bus1.req_addr  = v.req_addr;        bus1.req_wdata = v.req_wdata;
            bus1.data_in   = v.data_in;         bus1.ext_ready = v.ext_ready;
        end
    endtask

    task automatic checkOutput(input string name, input outv_t got, input outv_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: outputs got %h want %h", name, $time, got, exp);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Timeline model: every cycle of a transaction, with the inputs to drive and the outputs owed.
    task automatic planIdle(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.in = junkIn();
            c.in.req_valid = 1'b0;
            c.exp = idleOut();
            plan.push_back(c);
        end
    endtask

    task automatic planTxn(input int sel, input logic we, input logic [23:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int w0, input int w1);
        int aBeats, dBeats, aw, dw, w, n;
        bit abort, timedOut;
        logic [15:0] rd;
        logic [7:0] wSlice, rSlice;
        cyc_t c;
        aBeats = (sel == 0) ? 2 : 3;
        dBeats = (sel == 0) ? 1 : 2;
        aw = 8 * aBeats;
        dw = 8 * dBeats;
        rd = (dBeats == 1) ? {8'h00, rdata[7:0]} : rdata;
        abort = 1'b0;
        c.in = junkIn();
        c.in.req_valid = 1'b1;
        c.in.req_we    = we;
        c.in.req_addr  = addr;
        c.in.req_wdata = wdata;
        c.exp = idleOut();
        plan.push_back(c);
        for (int b = 0; b < aBeats; b++) begin
            c.in = junkIn();
            c.exp = '0;
            c.exp.busy = 1'b1;
            c.exp.ale = 1'b1;
            c.exp.rw_pin = ~we;
            c.exp.addr_pins = 8'(addr >> (aw - 8 * (b + 1)));
            plan.push_back(c);
        end
        for (int d = 0; d < dBeats; d++) begin
            if (!abort) begin
                w = (d == 0) ? w0 : w1;
                wSlice = 8'(wdata >> (dw - 8 * (d + 1)));
                rSlice = 8'(rd >> (dw - 8 * (d + 1)));
                timedOut = (TIMEOUT != 0) && (w >= TIMEOUT);
                n = timedOut ? TIMEOUT : w + 1;
                for (int k = 0; k < n; k++) begin
                    c.in = junkIn();
                    c.in.ext_ready = !timedOut && (k == n - 1);
                    if (c.in.ext_ready) c.in.data_in = rSlice;
                    c.exp = '0;
                    c.exp.busy = 1'b1;
                    c.exp.rw_pin = ~we;
                    if (we) begin
                        c.exp.data_out = wSlice;
                        c.exp.data_oe  = 8'hFF;
                    end
                    plan.push_back(c);
                end
                if (timedOut) abort = 1'b1;
            end
        end
        c.in = junkIn();
        c.exp = '0;
        c.exp.busy = 1'b1;
        c.exp.rw_pin = ~we;
        c.exp.rsp_valid = 1'b1;
        c.exp.rsp_err = abort;
        c.exp.rsp_rdata = (!we && !abort) ? rd : 16'h0000;
        plan.push_back(c);
    endtask

    task automatic clearCapture();
        rspAtQ.delete(); rspDataQ.delete(); rspErrQ.delete();
        aleQ.delete(); acceptQ.delete();
        oeCnt = 0;
    endtask

    task automatic applyStimulus(input int sel, input string label);
        cyc_t c;
        expSel = sel;
        curLabel = label;
        while (plan.size() > 0) begin
            @(posedge clk);
            #1;
            c = plan.pop_front();
            driveIn(sel, c.in);
            if (c.in.req_valid && c.exp.req_ready) acceptQ.push_back(cycleCnt + 1);
            expCur = c.exp;
            expOn = 1'b1;
        end
        @(negedge clk);
        #1;
        expOn = 1'b0;
    endtask

    always @(negedge clk) begin
        outv_t got;
        if (expOn) begin
            got = sampleOut(expSel);
            checkOutput(curLabel, got, expCur);
            if (got.rsp_valid) begin
                rspAtQ.push_back(cycleCnt + 1);
                rspDataQ.push_back(int'(got.rsp_rdata));
                rspErrQ.push_back(int'(got.rsp_err));
            end
            if (got.ale) aleQ.push_back(int'(got.addr_pins));
            if (got.data_oe == 8'hFF) oeCnt++;
        end
    end

    task automatic randomWaits(output int w);
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)       w = 0;
        else if (r < 7)  w = $urandom_range(1, 4);
        else if (r == 7) w = TIMEOUT - 1;
        else if (r == 8) w = TIMEOUT;
        else             w = $urandom_range(TIMEOUT + 1, 25);
    endtask

    initial begin
        int w0, w1, idx;
        cyc_t c;
        inv_t zero;
        zero = '0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            driveIn(0, junkIn());
            driveIn(1, junkIn());
            @(negedge clk);
            checkOutput("reset_dut0", sampleOut(0), idleOut());
            checkOutput("reset_dut1", sampleOut(1), idleOut());
        end
        checkValue("reset_rw_pin", int'(bus0.rw_pin), 1);
        driveIn(0, zero);
        driveIn(1, zero);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        @(posedge clk);
        #1;
        checkValue("post_reset_ready", int'(bus0.req_ready), 1);
        checkValue("post_reset_busy", int'(bus1.busy), 0);

        clearCapture();
        planTxn(0, 1'b0, 24'h001234, 16'h0000, 16'h00A5, 0, 0);
        planIdle(1);
        applyStimulus(0, "read_1234");
        checkValue("read_ale_beats", aleQ.size(), 2);
        if (aleQ.size() == 2) begin
            checkValue("read_addr_hi", aleQ[0], 'h12);
            checkValue("read_addr_lo", aleQ[1], 'h34);
        end
        checkValue("read_rsp_count", rspAtQ.size(), 1);
        if (rspAtQ.size() == 1 && acceptQ.size() == 1) begin
            checkValue("read_latency", rspAtQ[0] - acceptQ[0], 4);
            checkValue("read_rdata", rspDataQ[0], 'hA5);
            checkValue("read_err", rspErrQ[0], 0);
        end

        clearCapture();
        planTxn(0, 1'b1, 24'h0000FF, 16'h003C, 16'h0000, 2, 0);
        planIdle(1);
        applyStimulus(0, "write_waits");
        checkValue("write_oe_cycles", oeCnt, 3);
        checkValue("write_rsp_count", rspAtQ.size(), 1);
        if (rspAtQ.size() == 1 && acceptQ.size() == 1) begin
            checkValue("write_latency", rspAtQ[0] - acceptQ[0], 6);
            checkValue("write_rdata", rspDataQ[0], 0);
        end

        clearCapture();
        planTxn(0, 1'b0, 24'h004321, 16'h0000, 16'h0077, 100, 0);
        planTxn(0, 1'b0, 24'h004322, 16'h0000, 16'h0066, TIMEOUT - 1, 0);
        planIdle(1);
        applyStimulus(0, "timeout");
        checkValue("timeout_rsp_count", rspAtQ.size(), 2);
        if (rspAtQ.size() == 2 && acceptQ.size() == 2) begin
            checkValue("timeout_latency", rspAtQ[0] - acceptQ[0], 18);
            checkValue("timeout_err", rspErrQ[0], 1);
            checkValue("timeout_rdata", rspDataQ[0], 0);
            checkValue("near_timeout_err", rspErrQ[1], 0);
            checkValue("near_timeout_rdata", rspDataQ[1], 'h66);
        end

        clearCapture();
        planTxn(0, 1'b1, 24'h00BEEF, 16'h0055, 16'h0000, 10, 0);
        while (plan.size() > 6) void'(plan.pop_back());
        applyStimulus(0, "write_pre_reset");
        rst0_n = 1'b0;
        #1;
        checkValue("reset_oe_async", int'(bus0.data_oe), 0);
        checkValue("reset_busy_async", int'(bus0.busy), 0);
        @(negedge clk);
        checkValue("reset_no_rsp", int'(bus0.rsp_valid), 0);
        driveIn(0, zero);
        rst0_n = 1'b1;
        clearCapture();
        planTxn(0, 1'b1, 24'h000010, 16'h0099, 16'h0000, 1, 0);
        planIdle(1);
        applyStimulus(0, "after_reset");
        checkValue("after_reset_rsp", rspAtQ.size(), 1);

        clearCapture();
        planTxn(1, 1'b0, 24'hABCDEF, 16'h0000, 16'hDEAD, 0, 0);
        planIdle(1);
        applyStimulus(1, "wide_read");
        checkValue("wide_ale_beats", aleQ.size(), 3);
        if (aleQ.size() == 3) begin
            checkValue("wide_addr0", aleQ[0], 'hAB);
            checkValue("wide_addr1", aleQ[1], 'hCD);
            checkValue("wide_addr2", aleQ[2], 'hEF);
        end
        if (rspAtQ.size() == 1 && acceptQ.size() == 1) begin
            checkValue("wide_latency", rspAtQ[0] - acceptQ[0], 6);
            checkValue("wide_rdata", rspDataQ[0], 'hDEAD);
        end else begin
            checkValue("wide_rsp_count", rspAtQ.size(), 1);
        end

        clearCapture();
        idx = plan.size();
        planTxn(1, 1'b1, 24'h112233, 16'hBEEF, 16'h0000, 0, 0);
        for (int i = idx + 1; i < plan.size(); i++) begin
            c = plan[i];
            c.in.req_valid = 1'b1;
            c.in.req_we    = 1'b0;
            c.in.req_addr  = 24'h445566;
            c.in.req_wdata = 16'h0000;
            plan[i] = c;
        end
        planTxn(1, 1'b0, 24'h445566, 16'h0000, 16'h1357, 0, 0);
        planIdle(1);
        applyStimulus(1, "held_request");
        checkValue("held_rsp_count", rspAtQ.size(), 2);
        if (rspAtQ.size() == 2) begin
            checkValue("held_period", rspAtQ[1] - rspAtQ[0], 7);
            checkValue("held_rdata", rspDataQ[1], 'h1357);
        end

        for (int sel = 0; sel < 2; sel++) begin
            clearCapture();
            for (int t = 0; t < 40; t++) begin
                randomWaits(w0);
                randomWaits(w1);
                planTxn(sel, 1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom), w0, w1);
                planIdle($urandom_range(0, 2));
            end
            planIdle(1);
            applyStimulus(sel, (sel == 0) ? "random_dut0" : "random_dut1");
            checkValue((sel == 0) ? "random_rsp_dut0" : "random_rsp_dut1", rspAtQ.size(), 40);
        end

        $display("[TB] done");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
